// File: rtl/fetch_controller.sv
// fetch_controller
//   Owns the architectural fetch PC and runs a one-outstanding-request fetch
//   loop against instruction memory. The returned word is buffered for decode.
//   Branch/jump redirects from execute override everything; a redirect that
//   lands while a request is in flight marks that response for discard.
//
// State table
//   S_BOOT | first cycle after reset release, no request issued
//   S_REQ  | request presented to memory, waiting for ready
//   S_WAIT | request accepted, waiting for the response pulse
//   S_HOLD | instruction buffered and offered to decode
//
// Ports
//   clk, rst                     clock, async active-high reset
//   redirect, redirect_target    PC override from execute (target low 2 bits ignored)
//   stall                        decode cannot take the buffered instruction
//   imem_req_valid/ready/addr    request handshake, addr = low PC_WIDTH bits of pc
//   imem_rsp_valid/data          single-cycle response pulse and word
//   instr_valid, instr, instr_pc buffered instruction towards decode
//   pc                           next address to request
//   fetch_count                  instructions consumed by decode (wraps)
//   rsp_err                      sticky flag: response seen outside S_WAIT
module fetch_controller #(
  parameter int unsigned          OPD_WIDTH = 32,
  parameter int unsigned          PC_WIDTH  = 12,
  parameter logic [OPD_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect,
  input  logic [OPD_WIDTH-1:0] redirect_target,
  input  logic                 stall,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [PC_WIDTH-1:0]  imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [OPD_WIDTH-1:0] imem_rsp_data,
  output logic                 instr_valid,
  output logic [OPD_WIDTH-1:0] instr,
  output logic [OPD_WIDTH-1:0] instr_pc,
  output logic [OPD_WIDTH-1:0] pc,
  output logic [31:0]          fetch_count,
  output logic                 rsp_err
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [OPD_WIDTH-1:0] PC_STEP    = OPD_WIDTH'(4);
  localparam logic [OPD_WIDTH-1:0] ALIGN_MASK = ~OPD_WIDTH'(3);

  state_t               state;
  logic [OPD_WIDTH-1:0] fetch_pc;
  logic                 discard;
  logic [OPD_WIDTH-1:0] target;

  assign target = redirect_target & ALIGN_MASK;

  // Both valids are pure decodes of the state register, so they change only
  // on the clock edge.
  assign imem_req_valid = (state == S_REQ);
  assign instr_valid    = (state == S_HOLD);
  assign imem_req_addr  = pc[PC_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      fetch_pc    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      discard     <= 1'b0;
      fetch_count <= '0;
      rsp_err     <= 1'b0;
    end else begin
      // A response outside S_WAIT has no matching request (e.g. one left
      // over from before a reset); it is ignored but flagged.
      if (imem_rsp_valid && (state != S_WAIT)) rsp_err <= 1'b1;

      case (state)
        S_BOOT: begin
          if (redirect) pc <= target;
          state <= S_REQ;
        end

        S_REQ: begin
          if (imem_req_ready) begin
            state <= S_WAIT;
            if (redirect) begin
              // Memory took the old address; its reply is already stale.
              discard <= 1'b1;
              pc      <= target;
            end else begin
              fetch_pc <= pc;
              pc       <= pc + PC_STEP;
            end
          end else if (redirect) begin
            pc <= target;
          end
        end

        S_WAIT: begin
          if (redirect) begin
            pc <= target;
            if (imem_rsp_valid) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              discard <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              instr    <= imem_rsp_data;
              instr_pc <= fetch_pc;
              state    <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= S_REQ;
          end else if (!stall) begin
            fetch_count <= fetch_count + 32'd1;
            state       <= S_REQ;
          end
        end

        default: state <= S_BOOT;
      endcase
    end
  end

endmodule
